// File: rtl/cu_stream_feeder.sv
// cu_stream_feeder: writer-side front end for the computing unit.
// It demultiplexes one input vector stream into the weight, offset and
// activation FIFO write ports. It loads ACT_COUNT weight vectors, pulses
// weight_update_o, then feeds act_len offset/activation pairs.
// Optional build macro: CU_FEEDER_STATS_EN adds the stall_cycles_o and
// beats_o statistics outputs.
// Each data_type element is a DATA_WIDTH-bit word.
// state_o exposes the FSM state for debug:
// 0=IDLE 1=LOAD_W 2=UPDATE 3=PAIR_OFS 4=PAIR_ACT 5=FINISH.
module cu_stream_feeder #(
   parameter int ACT_COUNT    = 16,
   parameter int WEIGHT_COUNT = 16,
   parameter int LEN_WIDTH    = 16,
   parameter int DATA_WIDTH   = 16,
   localparam int IN_LANES    = (ACT_COUNT > WEIGHT_COUNT) ? ACT_COUNT : WEIGHT_COUNT
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [LEN_WIDTH-1:0]  act_len_i,
   output logic                  busy_o,
   output logic                  done_o,
   input  logic [DATA_WIDTH-1:0] in_data_i [0:IN_LANES-1],
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic                  cu_rst_busy_i,
   output logic [DATA_WIDTH-1:0] act_o [0:ACT_COUNT-1],
   output logic                  act_wr_en_o,
   input  logic                  act_full_i,
   output logic [DATA_WIDTH-1:0] weight_o [0:WEIGHT_COUNT-1],
   output logic                  weight_wr_en_o,
   input  logic                  weight_full_i,
   output logic [DATA_WIDTH-1:0] offset_o [0:WEIGHT_COUNT-1],
   output logic                  offset_wr_en_o,
   input  logic                  offset_full_i,
   output logic                  weight_update_o,
   output logic [2:0]            state_o
`ifdef CU_FEEDER_STATS_EN
   ,
   output logic [31:0]           stall_cycles_o,
   output logic [31:0]           beats_o
`endif
);

   localparam int W_CW = $clog2(ACT_COUNT + 1);

   typedef enum logic [2:0] {
      S_IDLE     = 3'd0,
      S_LOAD_W   = 3'd1,
      S_UPDATE   = 3'd2,
      S_PAIR_OFS = 3'd3,
      S_PAIR_ACT = 3'd4,
      S_FINISH   = 3'd5
   } state_t;

   state_t               state;
   logic [W_CW-1:0]      w_cnt;
   logic [LEN_WIDTH-1:0] p_cnt;
   logic [LEN_WIDTH-1:0] len;
   logic [LEN_WIDTH-1:0] p_cnt_inc;
   logic                 accept;

   // Handshake: a beat transfers on a rising clk_i edge where in_valid_i and
   // in_ready_o are both high. in_ready_o reflects the target FIFO's full
   // flag in the same cycle, so a write never lands in a full FIFO; the
   // source holds in_data_i stable while valid is high and ready is low.
   assign accept    = in_valid_i && in_ready_o;
   assign p_cnt_inc = p_cnt + LEN_WIDTH'(1);
   assign state_o   = state;

   // Ready follows the FIFO currently targeted; FIFO reset blocks every state.
   always_comb begin
      in_ready_o = 1'b0;
      if (!cu_rst_busy_i) begin
         case (state)
            S_LOAD_W:   in_ready_o = !weight_full_i;
            S_PAIR_OFS: in_ready_o = !offset_full_i;
            S_PAIR_ACT: in_ready_o = !act_full_i;
            default:    in_ready_o = 1'b0;
         endcase
      end
   end

   // Write enables go only to the targeted FIFO, with zero latency.
   always_comb begin
      weight_wr_en_o = accept && (state == S_LOAD_W);
      offset_wr_en_o = accept && (state == S_PAIR_OFS);
      act_wr_en_o    = accept && (state == S_PAIR_ACT);
   end

   // Data fan-out: each FIFO takes the low lanes of the beat, upper lanes drop.
   always_comb begin
      for (int i = 0; i < ACT_COUNT; i++) begin
         act_o[i] = in_data_i[i];
      end
      for (int i = 0; i < WEIGHT_COUNT; i++) begin
         weight_o[i] = in_data_i[i];
         offset_o[i] = in_data_i[i];
      end
   end

   // Batch sequencer with registered busy/done/update outputs.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state           <= S_IDLE;
         w_cnt           <= '0;
         p_cnt           <= '0;
         len             <= '0;
         busy_o          <= 1'b0;
         done_o          <= 1'b0;
         weight_update_o <= 1'b0;
      end else begin
         done_o          <= 1'b0;
         weight_update_o <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start_i) begin
                  len    <= act_len_i;
                  w_cnt  <= '0;
                  p_cnt  <= '0;
                  busy_o <= 1'b1;
                  state  <= S_LOAD_W;
               end
            end
            S_LOAD_W: begin
               if (accept) begin
                  if (w_cnt == W_CW'(ACT_COUNT - 1)) begin
                     w_cnt           <= '0;
                     weight_update_o <= 1'b1;
                     state           <= S_UPDATE;
                  end else begin
                     w_cnt <= w_cnt + W_CW'(1);
                  end
               end
            end
            S_UPDATE: begin
               if (len != '0) begin
                  state <= S_PAIR_OFS;
               end else begin
                  done_o <= 1'b1;
                  state  <= S_FINISH;
               end
            end
            S_PAIR_OFS: begin
               if (accept) begin
                  state <= S_PAIR_ACT;
               end
            end
            S_PAIR_ACT: begin
               if (accept) begin
                  p_cnt <= p_cnt_inc;
                  // Compared before any wrap, so a length of all-ones works.
                  if (p_cnt_inc == len) begin
                     done_o <= 1'b1;
                     state  <= S_FINISH;
                  end else begin
                     state <= S_PAIR_OFS;
                  end
               end
            end
            S_FINISH: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
            default: begin
               busy_o <= 1'b0;
               state  <= S_IDLE;
            end
         endcase
      end
   end

`ifdef CU_FEEDER_STATS_EN
   // Saturating stall and beat counters, cleared when a batch starts.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cycles_o <= '0;
         beats_o        <= '0;
      end else if (state == S_IDLE && start_i) begin
         stall_cycles_o <= '0;
         beats_o        <= '0;
      end else begin
         if (busy_o && in_valid_i && !in_ready_o && (stall_cycles_o != '1)) begin
            stall_cycles_o <= stall_cycles_o + 32'd1;
         end
         if (accept && (beats_o != '1)) begin
            beats_o <= beats_o + 32'd1;
         end
      end
   end
`endif

endmodule
